// File: rtl/posit_pkg.sv
// rtl/posit_pkg.sv - shared constants, FSM encoding and regime-length helper for the posit encoder
package posit_pkg;

    localparam int N     = 32;
    localparam int ES    = 3;
    localparam int CNT_W = 5;

    localparam logic [31:0] MAXPOS = 32'h7FFF_FFFF;
    localparam logic [31:0] MINPOS = 32'h0000_0001;
    localparam logic [31:0] ZERO   = 32'h0000_0000;

    typedef enum logic [2:0] {
        IDLE    = 3'd0,
        REGIME  = 3'd1,
        PACK    = 3'd2,
        ROUND   = 3'd3,
        DONE_ST = 3'd4
    } state_t;

    // k >= 0: k+1 ones plus a terminating zero; k < 0: -k zeros plus a terminating one
    function automatic logic [CNT_W-1:0] regime_len(input logic signed [5:0] k);
        int ki;
        ki = int'(k);
        if (ki >= 0) begin
            return CNT_W'(ki + 2);
        end
        return CNT_W'(1 - ki);
    endfunction

endpackage

// File: rtl/posit_round.sv
// rtl/posit_round.sv - round-to-nearest-even, saturation and sign application for a posit body
//
// Ports:
//   body   - unsigned posit body (everything after the sign bit)
//   g, s   - guard bit and sticky OR of the bits below the body
//   sign   - result sign; negative results are the two's complement of {0,body}
//   result - final N-bit posit word
module posit_round
    import posit_pkg::*;
#(
    parameter int N = posit_pkg::N
) (
    input  logic [N-2:0] body,
    input  logic         g,
    input  logic         s,
    input  logic         sign,
    output logic [N-1:0] result
);

    logic         inc;
    logic [N-2:0] rounded;
    logic [N-1:0] mag;

    always_comb begin
        // an all-ones body would carry into the sign position (NaR), so hold it at maxpos
        inc     = g & (body[0] | s) & ~(&body);
        rounded = body + {{(N-2){1'b0}}, inc};
        // a nonzero value must never collapse to zero
        if (rounded == '0) begin
            rounded = MINPOS[N-2:0];
        end
        mag    = {1'b0, rounded};
        result = sign ? (~mag + {{(N-1){1'b0}}, 1'b1}) : mag;
    end

endmodule

// File: rtl/posit_encoder.sv
// rtl/posit_encoder.sv - sequential posit encoder: regime serialisation, packing, rounding, handshake
//
// Ports:
//   clk, rst            - clock and asynchronous active-high reset
//   start               - operands valid; accepted only in IDLE
//   mant_adj            - normalised mantissa, bits[63:62]=01, fraction in bits[61:0]
//   adj_exp, adj_k      - exponent field and signed regime value k
//   sign_in             - result sign
//   ack                 - downstream has taken posit_out (honoured only in DONE_ST)
//   recieved            - one-cycle pulse when operands are captured
//   posit_out, done     - result word and its valid flag, held until ack
//   busy                - high whenever the FSM is not in IDLE
module posit_encoder
    import posit_pkg::*;
#(
    parameter int N  = posit_pkg::N,
    parameter int ES = posit_pkg::ES
) (
    input  logic         clk,
    input  logic         rst,
    input  logic         start,
    input  logic [63:0]  mant_adj,
    input  logic [2:0]   adj_exp,
    input  logic [5:0]   adj_k,
    input  logic         sign_in,
    input  logic         ack,
    output logic         recieved,
    output logic [N-1:0] posit_out,
    output logic         done,
    output logic         busy
);

    localparam int BW = N - 1;           // body width (posit without sign)
    localparam int FW = BW + ES + 62;    // regime slot + exponent + fraction

    state_t state, state_nxt;

    logic [61:0]      frac_q;
    logic [ES-1:0]    exp_q;
    logic             sign_q;
    logic             neg_q;
    logic             zero_q;
    logic [CNT_W-1:0] cnt;
    logic [CNT_W-1:0] r_q;
    logic [BW-1:0]    rg;
    logic [BW-1:0]    body_q;
    logic             g_q;
    logic             s_q;

    logic signed [5:0] k_s;
    logic              is_zero;
    logic              k_hi;
    logic              k_lo;
    logic              special;
    logic [FW-1:0]     packed_w;
    logic [N-1:0]      round_res;

    assign k_s     = adj_k;
    assign is_zero = (mant_adj == 64'd0);
    assign k_hi    = (k_s >= (N - 2));
    assign k_lo    = (k_s <= -(N - 1));
    assign special = is_zero | k_hi | k_lo;

    // rg holds the regime right-aligned in its low r_q bits; shifting left aligns it to the MSB
    assign packed_w = {rg, exp_q, frac_q} << (BW - int'(r_q));

    posit_round #(.N(N)) u_round (
        .body   (body_q),
        .g      (g_q),
        .s      (s_q),
        .sign   (sign_q),
        .result (round_res)
    );

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state <= IDLE;
        end else begin
            state <= state_nxt;
        end
    end

    always_comb begin
        state_nxt = state;
        case (state)
            IDLE:    if (start) state_nxt = special ? ROUND : REGIME;
            REGIME:  if (cnt == CNT_W'(1)) state_nxt = PACK;
            PACK:    state_nxt = ROUND;
            ROUND:   state_nxt = DONE_ST;
            DONE_ST: if (ack) state_nxt = IDLE;
            default: state_nxt = IDLE;
        endcase
    end

    always_comb begin
        busy = (state != IDLE);
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            recieved  <= 1'b0;
            posit_out <= '0;
            done      <= 1'b0;
            frac_q    <= '0;
            exp_q     <= '0;
            sign_q    <= 1'b0;
            neg_q     <= 1'b0;
            zero_q    <= 1'b0;
            cnt       <= '0;
            r_q       <= '0;
            rg        <= '0;
            body_q    <= '0;
            g_q       <= 1'b0;
            s_q       <= 1'b0;
        end else begin
            recieved <= 1'b0;
            case (state)
                IDLE: begin
                    if (start) begin
                        recieved <= 1'b1;
                        frac_q   <= mant_adj[61:0];
                        exp_q    <= adj_exp[ES-1:0];
                        sign_q   <= sign_in;
                        neg_q    <= adj_k[5];
                        zero_q   <= is_zero;
                        cnt      <= regime_len(k_s);
                        r_q      <= regime_len(k_s);
                        rg       <= '0;
                        g_q      <= 1'b0;
                        s_q      <= 1'b0;
                        // saturated cases skip straight to ROUND with a ready-made body
                        body_q   <= k_hi ? MAXPOS[BW-1:0] : (k_lo ? MINPOS[BW-1:0] : '0);
                    end
                end
                REGIME: begin
                    // run bits are ~neg_q, the final (terminating) bit is neg_q
                    rg  <= {rg[BW-2:0], (cnt == CNT_W'(1)) ? neg_q : ~neg_q};
                    cnt <= cnt - CNT_W'(1);
                end
                PACK: begin
                    body_q <= packed_w[FW-1 -: BW];
                    g_q    <= packed_w[FW-1-BW];
                    s_q    <= |packed_w[FW-2-BW:0];
                end
                ROUND: begin
                    posit_out <= zero_q ? ZERO[N-1:0] : round_res;
                    done      <= 1'b1;
                end
                DONE_ST: begin
                    if (ack) begin
                        done <= 1'b0;
                    end
                end
                default: ;
            endcase
        end
    end

endmodule

// File: tb/tb_posit_encoder.sv
// tb/tb_posit_encoder.sv - scoreboard bench for posit_encoder with directed vectors
module tb_posit_encoder;

    logic        clk = 1'b0;
    logic        rst = 1'b1;
    logic        start = 1'b0;
    logic [63:0] mant_adj = 64'd0;
    logic [2:0]  adj_exp = 3'd0;
    logic [5:0]  adj_k = 6'd0;
    logic        sign_in = 1'b0;
    logic        ack = 1'b0;
    logic        recieved;
    logic [31:0] posit_out;
    logic        done;
    logic        busy;

    posit_encoder dut (
        .clk       (clk),
        .rst       (rst),
        .start     (start),
        .mant_adj  (mant_adj),
        .adj_exp   (adj_exp),
        .adj_k     (adj_k),
        .sign_in   (sign_in),
        .ack       (ack),
        .recieved  (recieved),
        .posit_out (posit_out),
        .done      (done),
        .busy      (busy)
    );

    always #5 clk = ~clk;

    int cyc = 0;
    always @(posedge clk) cyc <= cyc + 1;

    int tests = 0;
    int fails = 0;

    typedef struct {
        string       name;
        logic [31:0] val;
        int          lat;
        int          start_cyc;
        int          hold;
    } exp_t;

    exp_t sb[$];

    localparam logic [63:0] M1 = 64'h4000_0000_0000_0000;

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] req);
        tests++;
        if (act !== req) begin
            fails++;
            $display("FAIL %s: got %h expected %h", name, act, req);
        end
    endtask

    task automatic wait_idle();
        int n = 0;
        @(negedge clk);
        while ((busy || done) && n < 300) begin
            @(negedge clk);
            n++;
        end
        if (n >= 300) begin
            tests++;
            fails++;
            $display("FAIL idle_timeout: busy=%0b done=%0b after %0d cycles", busy, done, n);
        end
    endtask

    task automatic issue(input string name, input logic [63:0] m, input logic [2:0] e,
                         input logic [5:0] k, input logic s, input logic [31:0] val,
                         input int lat, input int hold, input bit push);
        exp_t x;
        wait_idle();
        mant_adj = m;
        adj_exp  = e;
        adj_k    = k;
        sign_in  = s;
        start    = 1'b1;
        x.name      = name;
        x.val       = val;
        x.lat       = lat;
        x.hold      = hold;
        x.start_cyc = cyc + 1;
        if (push) sb.push_back(x);
        @(posedge clk);
        #1;
        check({name, "_rcv"}, {31'd0, recieved}, 32'd1);
        @(negedge clk);
        start = 1'b0;
    endtask

    task automatic poke_busy();
        @(negedge clk);
        mant_adj = 64'h7FFF_FFFF_FFFF_FFFF;
        adj_exp  = 3'd7;
        adj_k    = 6'd1;
        sign_in  = 1'b1;
        start    = 1'b1;
        @(posedge clk);
        #1;
        check("busy_start_rcv", {31'd0, recieved}, 32'd0);
        @(negedge clk);
        start = 1'b0;
    endtask

    // monitor: pops an expectation whenever the DUT presents a result, then acknowledges it
    initial begin
        exp_t e;
        bit   bad;
        forever begin
            @(negedge clk);
            if (done) begin
                if (sb.size() == 0) begin
                    tests++;
                    fails++;
                    $display("FAIL unexpected_done: got %h with empty scoreboard", posit_out);
                end else begin
                    e = sb.pop_front();
                    check(e.name, posit_out, e.val);
                    check({e.name, "_lat"}, 32'(cyc - e.start_cyc + 1), 32'(e.lat));
                    if (e.hold > 0) begin
                        bad = 1'b0;
                        repeat (e.hold) begin
                            @(negedge clk);
                            if (!done || posit_out !== e.val) bad = 1'b1;
                        end
                        tests++;
                        if (bad) begin
                            fails++;
                            $display("FAIL %s_hold: got done=%0b out=%h expected done=1 out=%h",
                                     e.name, done, posit_out, e.val);
                        end
                    end
                end
                ack = 1'b1;
                @(negedge clk);
                ack = 1'b0;
                check({e.name, "_clr"}, {31'd0, done}, 32'd0);
            end
        end
    end

    initial begin
        #400000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1, "watchdog");
    end

    initial begin
        int n;
        repeat (3) @(negedge clk);
        check("rst_out", posit_out, 32'd0);
        check("rst_flags", {29'd0, done, busy, recieved}, 32'd0);
        rst = 1'b0;
        @(posedge clk);
        #1;
        check("first_edge_quiet", {posit_out[0], 28'd0, done, busy, recieved}, 32'd0);

        issue("k0_pos",     M1, 3'd0, 6'd0,  1'b0, 32'h4000_0000, 5, 0, 1);
        issue("k0_neg",     M1, 3'd0, 6'd0,  1'b1, 32'hC000_0000, 5, 0, 1);
        issue("tie_even",   64'h4000_0008_0000_0000, 3'd0, 6'd0, 1'b0, 32'h4000_0000, 5, 0, 1);
        issue("tie_odd",    64'h4000_0018_0000_0000, 3'd0, 6'd0, 1'b0, 32'h4000_0002, 5, 0, 1);
        issue("tie_odd_ng", 64'h4000_0018_0000_0000, 3'd0, 6'd0, 1'b1, 32'hBFFF_FFFE, 5, 0, 1);
        issue("sticky_up",  64'h4000_0008_0000_0001, 3'd0, 6'd0, 1'b0, 32'h4000_0001, 5, 0, 1);
        issue("k31_pos",    M1, 3'd0, 6'd31, 1'b0, 32'h7FFF_FFFF, 2, 0, 1);
        issue("km32_pos",   M1, 3'd0, 6'h20, 1'b0, 32'h0000_0001, 2, 0, 1);
        issue("k31_neg",    M1, 3'd0, 6'd31, 1'b1, 32'h8000_0001, 2, 0, 1);
        issue("zero",       64'd0, 3'd5, 6'd3, 1'b0, 32'h0000_0000, 2, 0, 1);
        issue("zero_neg",   64'd0, 3'd0, 6'd31, 1'b1, 32'h0000_0000, 2, 0, 1);
        issue("k30_sat",    M1, 3'd2, 6'd30, 1'b0, 32'h7FFF_FFFF, 2, 0, 1);
        issue("km31_neg",   M1, 3'd2, 6'h21, 1'b1, 32'hFFFF_FFFF, 2, 0, 1);
        issue("k3_e2",      M1, 3'd2, 6'd3,  1'b0, 32'h7900_0000, 8, 0, 1);
        issue("km2_e5",     M1, 3'd5, 6'h3E, 1'b0, 32'h1A00_0000, 6, 0, 1);
        issue("k29_tie",    M1, 3'd4, 6'd29, 1'b0, 32'h7FFF_FFFE, 34, 0, 1);
        issue("k29_up",     M1, 3'd5, 6'd29, 1'b0, 32'h7FFF_FFFF, 34, 0, 1);
        issue("km30_up",    M1, 3'd4, 6'h22, 1'b0, 32'h0000_0002, 34, 0, 1);
        issue("km30_neg",   M1, 3'd0, 6'h22, 1'b1, 32'hFFFF_FFFF, 34, 0, 1);

        // long operation held for 10 cycles, with a second start attempted while busy
        issue("k20_hold",   M1, 3'd0, 6'd20, 1'b0, 32'h7FFF_FC00, 25, 10, 1);
        repeat (3) @(negedge clk);
        poke_busy();

        // reset in the middle of the regime phase
        issue("k20_abort",  M1, 3'd0, 6'd20, 1'b0, 32'h0, 25, 0, 0);
        repeat (5) @(negedge clk);
        rst = 1'b1;
        #1;
        check("midrst_out", posit_out, 32'd0);
        check("midrst_flags", {29'd0, done, busy, recieved}, 32'd0);
        @(negedge clk);
        rst = 1'b0;
        @(posedge clk);
        #1;
        check("midrst_quiet", {29'd0, done, busy, recieved}, 32'd0);

        issue("km1_e5",     M1, 3'd5, 6'h3F, 1'b0, 32'h3400_0000, 5, 0, 1);

        n = 0;
        while ((sb.size() != 0 || busy || done) && n < 2000) begin
            @(negedge clk);
            n++;
        end
        if (n >= 2000) begin
            tests++;
            fails++;
            $display("FAIL drain_timeout: %0d results still pending", sb.size());
        end
        repeat (3) @(negedge clk);
        $display("[TB] %0d tests run, %0d failed", tests, fails);
        $finish;
    end

endmodule
